bp_update_unit: RTL and testbench

BP_UPDATE_UNIT -- requirements
Module: bp_update_unit

---
 rtl/my_pkg.sv | 29 ++
 rtl/bp_update_unit_if.sv | 12 +
 rtl/bp_fifo.sv | 47 ++++
 rtl/bp_update_unit.sv | 101 ++++++++++
 tb/tb_bp_update_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/my_pkg.sv
// Shared types for the branch-predictor update path: record layout, kind encoding
// and the default update-queue depth.
package my_pkg;

   localparam int BPQ_DEPTH = 4;

   typedef enum logic [1:0] {
      UPD_BRANCH = 2'd0,
      UPD_JAL    = 2'd1,
      UPD_JALR   = 2'd2
   } upd_kind_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
      upd_kind_t   kind;
   } bp_upd_t;

   localparam int BP_UPD_W = $bits(bp_upd_t);

   // JALR outranks JAL, which outranks a conditional branch
   function automatic upd_kind_t upd_kind(input logic jumpr, input logic jump);
      if (jumpr) return UPD_JALR;
      if (jump)  return UPD_JAL;
      return UPD_BRANCH;
   endfunction

endpackage

// File: rtl/bp_update_unit_if.sv
// Valid/ready update stream from the EX-stage resolver to the predictor tables.
interface bp_update_unit_if;
   import my_pkg::*;

   logic    upd_valid;
   logic    upd_ready;
   bp_upd_t upd_data;

   modport master (output upd_valid, output upd_data, input upd_ready);
   modport slave  (input upd_valid, input upd_data, output upd_ready);

endinterface

// File: rtl/bp_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; a push into a full queue is
// accepted only when a pop happens in the same cycle.
module bp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Storage is not reset, so the head is masked to keep the bus at zero when empty
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bp_update_unit.sv
// EX-stage branch resolution: flags mispredictions, supplies the redirect PC and
// queues predictor-update records, with saturating performance counters.
module bp_update_unit
   import my_pkg::*;
#(
   parameter int DEPTH = BPQ_DEPTH,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               BranchE,
   input  logic               JumpE,
   input  logic               JumprE,
   input  logic               br_actualE,
   input  logic               br_predictE,
   input  logic               StallE,
   input  logic [31:0]        PCE,
   input  logic [31:0]        PCPlus4E,
   input  logic [31:0]        PCTargetE,
   input  logic [31:0]        ALUResultE,
   input  logic [31:0]        PredTargetE,
   output logic               mispredictE,
   output logic [31:0]        PCRedirectE,
   bp_update_unit_if.master   upd,
   input  logic               perf_clr,
   output logic [CNT_W-1:0]   cnt_branch,
   output logic [CNT_W-1:0]   cnt_mispredict,
   output logic [CNT_W-1:0]   cnt_drop
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic                ctrl_e;
   logic                fire;
   logic                actual_taken;
   logic [31:0]         actual_target;
   logic                push;
   logic                pop;
   logic                drop;
   logic                q_full;
   logic                q_empty;
   bp_upd_t             rec;
   logic [BP_UPD_W-1:0] q_dout;

   assign ctrl_e        = BranchE | JumpE | JumprE;
   assign fire          = ~StallE & (ctrl_e | br_predictE);
   assign actual_taken  = JumpE | JumprE | (BranchE & br_actualE);
   assign actual_target = JumprE ? (ALUResultE & ~32'd1) : PCTargetE;

   // A predicted-taken non-control instruction resolves as not taken, so it redirects to PC+4
   assign mispredictE = fire & ((br_predictE != actual_taken) |
                                (br_predictE & actual_taken & (PredTargetE != actual_target)));
   assign PCRedirectE = actual_taken ? actual_target : PCPlus4E;

   assign push = fire & ctrl_e;
   assign pop  = ~q_empty & upd.upd_ready;
   assign drop = push & q_full & ~pop;

   always_comb begin
      rec        = '0;
      rec.pc     = PCE;
      rec.target = actual_target;
      rec.taken  = actual_taken;
      rec.kind   = upd_kind(JumprE, JumpE);
   end

   bp_fifo #(
      .WIDTH (BP_UPD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (rec),
      .dout  (q_dout),
      .full  (q_full),
      .empty (q_empty)
   );

   assign upd.upd_valid = ~q_empty;
   assign upd.upd_data  = bp_upd_t'(q_dout);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_branch     <= '0;
         cnt_mispredict <= '0;
         cnt_drop       <= '0;
      end else if (perf_clr) begin
         cnt_branch     <= '0;
         cnt_mispredict <= '0;
         cnt_drop       <= '0;
      end else begin
         if (push && cnt_branch != CNT_MAX)            cnt_branch     <= cnt_branch + CNT_ONE;
         if (mispredictE && cnt_mispredict != CNT_MAX) cnt_mispredict <= cnt_mispredict + CNT_ONE;
         if (drop && cnt_drop != CNT_MAX)              cnt_drop       <= cnt_drop + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_bp_update_unit.sv
// Bench for bp_update_unit: directed scenarios plus randomized traffic against a
// queue-based reference model; a narrow-counter twin instance checks saturation.
module tb_bp_update_unit;
   import my_pkg::*;

   localparam int DEPTH = 4;
   localparam int SAT_W = 2;

   logic clk = 1'b0;
   logic reset;
   logic BranchE, JumpE, JumprE, br_actualE, br_predictE, StallE, perf_clr;
   logic [31:0] PCE, PCPlus4E, PCTargetE, ALUResultE, PredTargetE;
   logic mispredictE, s_mispredictE;
   logic [31:0] PCRedirectE, s_PCRedirectE;
   logic [31:0] cnt_branch, cnt_mispredict, cnt_drop;
   logic [SAT_W-1:0] s_branch, s_mispredict, s_drop;

   int tests_run = 0;
   int tests_failed = 0;

   bp_update_unit_if upd ();
   bp_update_unit_if upd_s ();
   assign upd_s.upd_ready = upd.upd_ready;

   always #5 clk = ~clk;

   bp_update_unit #(.DEPTH(DEPTH), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .BranchE(BranchE), .JumpE(JumpE), .JumprE(JumprE),
      .br_actualE(br_actualE), .br_predictE(br_predictE), .StallE(StallE),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE),
      .ALUResultE(ALUResultE), .PredTargetE(PredTargetE),
      .mispredictE(mispredictE), .PCRedirectE(PCRedirectE),
      .upd(upd), .perf_clr(perf_clr),
      .cnt_branch(cnt_branch), .cnt_mispredict(cnt_mispredict), .cnt_drop(cnt_drop)
   );

   bp_update_unit #(.DEPTH(DEPTH), .CNT_W(SAT_W)) dut_sat (
      .clk(clk), .reset(reset),
      .BranchE(BranchE), .JumpE(JumpE), .JumprE(JumprE),
      .br_actualE(br_actualE), .br_predictE(br_predictE), .StallE(StallE),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE),
      .ALUResultE(ALUResultE), .PredTargetE(PredTargetE),
      .mispredictE(s_mispredictE), .PCRedirectE(s_PCRedirectE),
      .upd(upd_s), .perf_clr(perf_clr),
      .cnt_branch(s_branch), .cnt_mispredict(s_mispredict), .cnt_drop(s_drop)
   );

   // ---------------- reference model ----------------
   bp_upd_t mq[$];
   longint  m_branch, m_misp, m_drop;

   function automatic logic f_ctrl();
      return BranchE | JumpE | JumprE;
   endfunction
   function automatic logic f_fire();
      return !StallE && (f_ctrl() || br_predictE);
   endfunction
   function automatic logic f_taken();
      return JumpE || JumprE || (BranchE && br_actualE);
   endfunction
   function automatic logic [31:0] f_target();
      return JumprE ? {ALUResultE[31:1], 1'b0} : PCTargetE;
   endfunction
   function automatic logic f_misp();
      if (!f_fire()) return 1'b0;
      if (br_predictE != f_taken()) return 1'b1;
      return br_predictE && f_taken() && (PredTargetE != f_target());
   endfunction
   function automatic logic [31:0] f_redirect();
      return f_taken() ? f_target() : PCPlus4E;
   endfunction
   function automatic bp_upd_t f_rec();
      bp_upd_t r;
      r.pc     = PCE;
      r.target = f_target();
      r.taken  = f_taken();
      r.kind   = JumprE ? UPD_JALR : (JumpE ? UPD_JAL : UPD_BRANCH);
      return r;
   endfunction
   function automatic longint sat(longint v, int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_branch = 0;
      m_misp   = 0;
      m_drop   = 0;
   endtask

   // Samples the current inputs, advances one clock edge and updates the model
   task automatic model_edge();
      logic push, pop, misp, clr;
      bp_upd_t r;
      push = f_fire() && f_ctrl();
      pop  = (mq.size() != 0) && upd.upd_ready;
      misp = f_misp();
      clr  = perf_clr;
      r    = f_rec();
      @(posedge clk);
      if (pop) mq.delete(0);
      if (clr) begin
         m_branch = 0; m_misp = 0; m_drop = 0;
      end else begin
         if (push) m_branch++;
         if (misp) m_misp++;
         if (push && mq.size() >= DEPTH) m_drop++;
      end
      if (push && mq.size() < DEPTH) mq.push_back(r);
      #1;
   endtask

   task automatic set_idle();
      BranchE = 0; JumpE = 0; JumprE = 0; br_actualE = 0; br_predictE = 0; StallE = 0;
      PCE = 0; PCPlus4E = 0; PCTargetE = 0; ALUResultE = 0; PredTargetE = 0;
   endtask

   task automatic set_branch(input logic [31:0] pc, input logic act, input logic pred);
      set_idle();
      BranchE = 1; br_actualE = act; br_predictE = pred;
      PCE = pc; PCPlus4E = pc + 4; PCTargetE = pc + 32'h40; PredTargetE = pc + 32'h40;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1; perf_clr = 0; upd.upd_ready = 0; set_idle();
      #12;
      tests_run++;
      if (upd.upd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", upd.upd_valid); end
      tests_run++;
      if (upd.upd_data !== bp_upd_t'(0)) begin tests_failed++; $display("FAIL reset_data: got %h want 0", upd.upd_data); end
      tests_run++;
      if ({cnt_branch, cnt_mispredict, cnt_drop} !== 96'd0) begin tests_failed++; $display("FAIL reset_cnt: got %h/%h/%h want 0", cnt_branch, cnt_mispredict, cnt_drop); end
      model_reset();
      @(negedge clk); reset = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_branch_mispredict();
      bp_upd_t e;
      set_idle(); BranchE = 1; br_actualE = 1; br_predictE = 0;
      PCE = 32'h80; PCPlus4E = 32'h84; PCTargetE = 32'h100; upd.upd_ready = 0;
      #1;
      tests_run++;
      if (mispredictE !== 1'b1) begin tests_failed++; $display("FAIL br_misp: got %b want 1", mispredictE); end
      tests_run++;
      if (PCRedirectE !== 32'h100) begin tests_failed++; $display("FAIL br_redirect: got %h want 100", PCRedirectE); end
      model_edge();
      set_idle(); #1;
      e.pc = 32'h80; e.target = 32'h100; e.taken = 1'b1; e.kind = UPD_BRANCH;
      tests_run++;
      if (upd.upd_valid !== 1'b1 || upd.upd_data !== e) begin tests_failed++; $display("FAIL br_record: got v=%b %h want v=1 %h", upd.upd_valid, upd.upd_data, e); end
      tests_run++;
      if (cnt_mispredict !== 32'd1 || cnt_branch !== 32'd1) begin tests_failed++; $display("FAIL br_counters: got misp=%0d br=%0d want 1/1", cnt_mispredict, cnt_branch); end
      upd.upd_ready = 1; model_edge();
      tests_run++;
      if (upd.upd_valid !== 1'b0) begin tests_failed++; $display("FAIL br_drain: got valid %b want 0", upd.upd_valid); end
   endtask

   task automatic test_jalr();
      set_idle(); JumprE = 1; ALUResultE = 32'h203; br_predictE = 1; PredTargetE = 32'h202;
      PCE = 32'h200; PCPlus4E = 32'h204; upd.upd_ready = 0;
      #1;
      tests_run++;
      if (mispredictE !== 1'b0 || PCRedirectE !== 32'h202) begin tests_failed++; $display("FAIL jalr_comb: got misp=%b pc=%h want 0/202", mispredictE, PCRedirectE); end
      model_edge();
      set_idle(); #1;
      tests_run++;
      if (upd.upd_data.target !== 32'h202 || upd.upd_data.kind !== UPD_JALR || upd.upd_data.taken !== 1'b1) begin
         tests_failed++; $display("FAIL jalr_record: got %h want target=202 kind=JALR taken=1", upd.upd_data);
      end
      upd.upd_ready = 1; model_edge();
   endtask

   task automatic test_nonctrl();
      longint b0;
      b0 = m_branch;
      set_idle(); br_predictE = 1; PCE = 32'h40; PCPlus4E = 32'h44; PredTargetE = 32'h90;
      #1;
      tests_run++;
      if (mispredictE !== 1'b1 || PCRedirectE !== 32'h44) begin tests_failed++; $display("FAIL nonctrl_comb: got misp=%b pc=%h want 1/44", mispredictE, PCRedirectE); end
      model_edge();
      set_idle(); #1;
      tests_run++;
      if (upd.upd_valid !== 1'b0 || cnt_branch !== 32'(b0)) begin tests_failed++; $display("FAIL nonctrl_nopush: got v=%b br=%0d want 0/%0d", upd.upd_valid, cnt_branch, b0); end
   endtask

   task automatic test_drop();
      set_idle(); perf_clr = 1; model_edge(); perf_clr = 0;
      upd.upd_ready = 0;
      for (int i = 0; i < 5; i++) begin
         set_branch(32'h1000 + 32'(i * 4), 1'b0, 1'b0);
         #1;
         if (i > 0) begin
            tests_run++;
            if (upd.upd_data.pc !== 32'h1000) begin tests_failed++; $display("FAIL drop_hold: got pc %h want 1000", upd.upd_data.pc); end
         end
         model_edge();
      end
      set_idle(); #1;
      tests_run++;
      if (cnt_drop !== 32'd1 || cnt_branch !== 32'd5) begin tests_failed++; $display("FAIL drop_cnt: got drop=%0d br=%0d want 1/5", cnt_drop, cnt_branch); end
      tests_run++;
      if (s_branch !== 2'd3) begin tests_failed++; $display("FAIL drop_sat: got %0d want 3", s_branch); end
      upd.upd_ready = 1;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (upd.upd_valid !== 1'b1 || upd.upd_data.pc !== 32'h1000 + 32'(i * 4)) begin
            tests_failed++; $display("FAIL drop_order%0d: got v=%b pc=%h want 1/%h", i, upd.upd_valid, upd.upd_data.pc, 32'h1000 + 32'(i * 4));
         end
         model_edge();
      end
      tests_run++;
      if (upd.upd_valid !== 1'b0) begin tests_failed++; $display("FAIL drop_empty: got valid %b want 0", upd.upd_valid); end
   endtask

   task automatic test_back_to_back();
      longint d0, b0;
      d0 = m_drop;
      upd.upd_ready = 0;
      for (int i = 0; i < 4; i++) begin set_branch(32'h3000 + 32'(i * 4), 1'b1, 1'b1); model_edge(); end
      set_branch(32'h3010, 1'b1, 1'b1); upd.upd_ready = 1; model_edge();
      set_idle(); upd.upd_ready = 0; #1;
      tests_run++;
      if (cnt_drop !== 32'(d0)) begin tests_failed++; $display("FAIL full_pp_drop: got %0d want %0d", cnt_drop, d0); end
      upd.upd_ready = 1;
      for (int i = 1; i < 5; i++) begin
         tests_run++;
         if (upd.upd_valid !== 1'b1 || upd.upd_data.pc !== 32'h3000 + 32'(i * 4)) begin
            tests_failed++; $display("FAIL full_pp_order%0d: got v=%b pc=%h want 1/%h", i, upd.upd_valid, upd.upd_data.pc, 32'h3000 + 32'(i * 4));
         end
         model_edge();
      end
      tests_run++;
      if (upd.upd_valid !== 1'b0) begin tests_failed++; $display("FAIL full_pp_count: got valid %b want 0", upd.upd_valid); end
      // instruction held in EX by a 3-cycle stall, then released
      b0 = m_branch; upd.upd_ready = 0;
      set_branch(32'h5000, 1'b0, 1'b0); StallE = 1;
      for (int i = 0; i < 3; i++) model_edge();
      StallE = 0; model_edge();
      set_idle(); #1;
      tests_run++;
      if (cnt_branch !== 32'(b0 + 1) || upd.upd_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_once: got br=%0d v=%b want %0d/1", cnt_branch, upd.upd_valid, b0 + 1); end
      upd.upd_ready = 1; model_edge();
      tests_run++;
      if (upd.upd_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_single: got valid %b want 0", upd.upd_valid); end
      // push into an empty queue while ready: no bypass
      set_branch(32'h6000, 1'b0, 1'b0); #1;
      tests_run++;
      if (upd.upd_valid !== 1'b0) begin tests_failed++; $display("FAIL nobypass_same: got valid %b want 0", upd.upd_valid); end
      model_edge();
      set_idle(); #1;
      tests_run++;
      if (upd.upd_valid !== 1'b1 || upd.upd_data.pc !== 32'h6000) begin tests_failed++; $display("FAIL nobypass_next: got v=%b pc=%h want 1/6000", upd.upd_valid, upd.upd_data.pc); end
      model_edge();
   endtask

   task automatic test_reset_mid();
      upd.upd_ready = 0;
      for (int i = 0; i < 3; i++) begin set_branch(32'h7000 + 32'(i * 4), 1'b1, 1'b0); model_edge(); end
      set_idle(); upd.upd_ready = 1; model_edge();
      #2 reset = 1;
      #1;
      tests_run++;
      if (upd.upd_valid !== 1'b0 || upd.upd_data !== bp_upd_t'(0)) begin tests_failed++; $display("FAIL midreset_q: got v=%b d=%h want 0/0", upd.upd_valid, upd.upd_data); end
      tests_run++;
      if ({cnt_branch, cnt_mispredict, cnt_drop} !== 96'd0 || {s_branch, s_mispredict, s_drop} !== 6'd0) begin
         tests_failed++; $display("FAIL midreset_cnt: got %0d/%0d/%0d want 0", cnt_branch, cnt_mispredict, cnt_drop);
      end
      model_reset();
      @(negedge clk); reset = 0;
      @(posedge clk); #1;
      set_branch(32'h8000, 1'b1, 1'b0); model_edge();
      perf_clr = 1; #1;
      tests_run++;
      if (mispredictE !== 1'b1) begin tests_failed++; $display("FAIL clr_misp_comb: got %b want 1", mispredictE); end
      model_edge();
      perf_clr = 0; set_idle(); #1;
      tests_run++;
      if (cnt_mispredict !== 32'd0 || cnt_branch !== 32'd0) begin tests_failed++; $display("FAIL clr_priority: got misp=%0d br=%0d want 0/0", cnt_mispredict, cnt_branch); end
      model_edge();
   endtask

   task automatic test_random();
      bp_upd_t h;
      for (int n = 0; n < 400; n++) begin
         set_idle();
         BranchE     = ($urandom_range(0, 2) == 0);
         JumpE       = ($urandom_range(0, 5) == 0);
         JumprE      = ($urandom_range(0, 5) == 0);
         br_actualE  = $urandom_range(0, 1);
         br_predictE = ($urandom_range(0, 2) == 0);
         StallE      = ($urandom_range(0, 4) == 0);
         PCE         = {$urandom_range(0, 255), 2'b00};
         PCPlus4E    = PCE + 4;
         PCTargetE   = 32'h100 + {$urandom_range(0, 3), 2'b00};
         ALUResultE  = 32'h200 + 32'($urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0: PredTargetE = PCTargetE;
            1: PredTargetE = ALUResultE & ~32'd1;
            default: PredTargetE = 32'h100 + 32'($urandom_range(0, 15));
         endcase
         upd.upd_ready = $urandom_range(0, 1);
         perf_clr      = ($urandom_range(0, 39) == 0);
         #1;
         tests_run++;
         if (mispredictE !== f_misp() || PCRedirectE !== f_redirect()) begin
            tests_failed++; $display("FAIL rnd_comb@%0d: got misp=%b pc=%h want %b/%h", n, mispredictE, PCRedirectE, f_misp(), f_redirect());
         end
         tests_run++;
         if (upd.upd_valid !== (mq.size() != 0)) begin tests_failed++; $display("FAIL rnd_valid@%0d: got %b want %b", n, upd.upd_valid, mq.size() != 0); end
         if (mq.size() != 0) begin
            h = mq[0];
            tests_run++;
            if (upd.upd_data !== h) begin tests_failed++; $display("FAIL rnd_data@%0d: got %h want %h", n, upd.upd_data, h); end
         end
         tests_run++;
         if (cnt_branch !== 32'(m_branch) || cnt_mispredict !== 32'(m_misp) || cnt_drop !== 32'(m_drop)) begin
            tests_failed++; $display("FAIL rnd_cnt@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", n, cnt_branch, cnt_mispredict, cnt_drop, m_branch, m_misp, m_drop);
         end
         tests_run++;
         if (s_branch !== SAT_W'(sat(m_branch, SAT_W)) || s_mispredict !== SAT_W'(sat(m_misp, SAT_W)) || s_drop !== SAT_W'(sat(m_drop, SAT_W))) begin
            tests_failed++; $display("FAIL rnd_sat@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", n, s_branch, s_mispredict, s_drop,
                                     sat(m_branch, SAT_W), sat(m_misp, SAT_W), sat(m_drop, SAT_W));
         end
         model_edge();
      end
      perf_clr = 0;
   endtask

   initial begin
      test_reset();
      test_branch_mispredict();
      test_jalr();
      test_nonctrl();
      test_drop();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
